// File: rtl/unidade_controle_quiz.sv
// rtl/unidade_controle_quiz.sv - Moore control unit sequencing the flag-quiz rounds
module unidade_controle_quiz #(
    parameter bit TIMEOUT_ENCERRA = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       dificuldade,
    input  logic       fez_jogada,
    input  logic       jogada_igual_memoria,
    input  logic       ultima_jogada,
    input  logic       deu_timeout,
    input  logic       fim_timer_resultado,
    output logic       dificuldade_travada,
    output logic       zera_contador_jogada,
    output logic       zera_contador_score,
    output logic       zera_timer_resultado,
    output logic       zera_timeout,
    output logic       zeraR,
    output logic       conta_jogada,
    output logic       conta_score,
    output logic       conta_timer_resultado,
    output logic       conta_timeout,
    output logic       registraR,
    output logic       liga_led,
    output logic       led_acerto,
    output logic       led_erro,
    output logic       pronto,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam logic [3:0] INICIAL    = 4'd0;
    localparam logic [3:0] PREPARACAO = 4'd1;
    localparam logic [3:0] ESPERA     = 4'd2;
    localparam logic [3:0] REGISTRA   = 4'd3;
    localparam logic [3:0] COMPARA    = 4'd4;
    localparam logic [3:0] ACERTO     = 4'd5;
    localparam logic [3:0] ERRO       = 4'd6;
    localparam logic [3:0] TIMEOUT    = 4'd7;
    localparam logic [3:0] EXIBE      = 4'd8;
    localparam logic [3:0] PROXIMA    = 4'd9;
    localparam logic [3:0] FIM        = 4'd10;

    logic [3:0] estado_q, estado_d;
    logic       acertou_q, acertou_d;
    logic       db_timeout_q, db_timeout_d;
    logic       dificuldade_travada_q, dificuldade_travada_d;
    logic       em_jogo;

    always_comb begin
        estado_d              = estado_q;
        acertou_d             = acertou_q;
        db_timeout_d          = db_timeout_q;
        dificuldade_travada_d = dificuldade_travada_q;
        case (estado_q)
            INICIAL:    if (iniciar) estado_d = PREPARACAO;
            PREPARACAO: begin
                dificuldade_travada_d = dificuldade;
                acertou_d             = 1'b0;
                db_timeout_d          = 1'b0;
                estado_d              = ESPERA;
            end
            // A button press outranks a timeout arriving in the same cycle.
            ESPERA: begin
                if (fez_jogada)       estado_d = REGISTRA;
                else if (deu_timeout) estado_d = TIMEOUT;
            end
            REGISTRA:   estado_d = COMPARA;
            COMPARA:    estado_d = jogada_igual_memoria ? ACERTO : ERRO;
            ACERTO: begin
                acertou_d = 1'b1;
                estado_d  = EXIBE;
            end
            ERRO: begin
                acertou_d = 1'b0;
                estado_d  = EXIBE;
            end
            TIMEOUT: begin
                acertou_d    = 1'b0;
                db_timeout_d = 1'b1;
                estado_d     = EXIBE;
            end
            EXIBE: begin
                if (fim_timer_resultado) begin
                    if (ultima_jogada || (TIMEOUT_ENCERRA && db_timeout_q)) estado_d = FIM;
                    else                                                     estado_d = PROXIMA;
                end
            end
            PROXIMA: begin
                db_timeout_d = 1'b0;
                estado_d     = ESPERA;
            end
            FIM:        if (iniciar) estado_d = PREPARACAO;
            default:    estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q              <= INICIAL;
            acertou_q             <= 1'b0;
            db_timeout_q          <= 1'b0;
            dificuldade_travada_q <= 1'b0;
        end else begin
            estado_q              <= estado_d;
            acertou_q             <= acertou_d;
            db_timeout_q          <= db_timeout_d;
            dificuldade_travada_q <= dificuldade_travada_d;
        end
    end

    // Flags are masked outside the legal game states so INICIAL and stray codes stay silent.
    assign em_jogo             = (estado_q >= PREPARACAO) && (estado_q <= FIM);
    assign dificuldade_travada = dificuldade_travada_q & em_jogo;
    assign db_timeout          = db_timeout_q & em_jogo;
    assign db_estado           = estado_q;

    always_comb begin
        zera_contador_jogada  = 1'b0;
        zera_contador_score   = 1'b0;
        zera_timer_resultado  = 1'b0;
        zera_timeout          = 1'b0;
        zeraR                 = 1'b0;
        conta_jogada          = 1'b0;
        conta_score           = 1'b0;
        conta_timer_resultado = 1'b0;
        conta_timeout         = 1'b0;
        registraR             = 1'b0;
        liga_led              = 1'b0;
        led_acerto            = 1'b0;
        led_erro              = 1'b0;
        pronto                = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zera_contador_jogada = 1'b1;
                zera_contador_score  = 1'b1;
                zera_timer_resultado = 1'b1;
                zera_timeout         = 1'b1;
                zeraR                = 1'b1;
            end
            ESPERA: begin
                liga_led      = 1'b1;
                conta_timeout = 1'b1;
            end
            REGISTRA: begin
                liga_led  = 1'b1;
                registraR = 1'b1;
            end
            COMPARA:  liga_led = 1'b1;
            ACERTO: begin
                conta_score          = 1'b1;
                zera_timer_resultado = 1'b1;
            end
            ERRO:     zera_timer_resultado = 1'b1;
            TIMEOUT:  zera_timer_resultado = 1'b1;
            EXIBE: begin
                conta_timer_resultado = 1'b1;
                led_acerto            = acertou_q;
                led_erro              = ~acertou_q;
            end
            PROXIMA: begin
                conta_jogada = 1'b1;
                zera_timeout = 1'b1;
                zeraR        = 1'b1;
            end
            FIM:      pronto = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_quiz.sv
// tb/tb_unidade_controle_quiz.sv - table-driven checks of the quiz control unit
module tb_unidade_controle_quiz;

    localparam logic [15:0] DT   = 16'h0001;
    localparam logic [15:0] ZALL = 16'h003E;
    localparam logic [15:0] ZTR  = 16'h0008;
    localparam logic [15:0] ZT   = 16'h0010;
    localparam logic [15:0] ZR   = 16'h0020;
    localparam logic [15:0] CJ   = 16'h0040;
    localparam logic [15:0] CS   = 16'h0080;
    localparam logic [15:0] CTR  = 16'h0100;
    localparam logic [15:0] CT   = 16'h0200;
    localparam logic [15:0] REG  = 16'h0400;
    localparam logic [15:0] LED  = 16'h0800;
    localparam logic [15:0] LA   = 16'h1000;
    localparam logic [15:0] LE   = 16'h2000;
    localparam logic [15:0] PR   = 16'h4000;
    localparam logic [15:0] DBT  = 16'h8000;

    typedef struct {
        logic [7:0]  inp;   // {reset, iniciar, dificuldade, fez, igual, ultima, deu, fim}
        logic [3:0]  st;
        logic [15:0] mask;
    } vec_t;

    logic clock = 1'b0;
    logic reset, iniciar, dificuldade, fez_jogada, jogada_igual_memoria;
    logic ultima_jogada, deu_timeout, fim_timer_resultado;
    logic [19:0] o0, o1;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   n_cs  = 0;
    int   n_cj  = 0;

    always #5 clock = ~clock;

    unidade_controle_quiz #(.TIMEOUT_ENCERRA(1'b0)) dut0 (
        .clock(clock), .reset(reset), .iniciar(iniciar), .dificuldade(dificuldade),
        .fez_jogada(fez_jogada), .jogada_igual_memoria(jogada_igual_memoria),
        .ultima_jogada(ultima_jogada), .deu_timeout(deu_timeout),
        .fim_timer_resultado(fim_timer_resultado),
        .dificuldade_travada(o0[0]), .zera_contador_jogada(o0[1]), .zera_contador_score(o0[2]),
        .zera_timer_resultado(o0[3]), .zera_timeout(o0[4]), .zeraR(o0[5]),
        .conta_jogada(o0[6]), .conta_score(o0[7]), .conta_timer_resultado(o0[8]),
        .conta_timeout(o0[9]), .registraR(o0[10]), .liga_led(o0[11]),
        .led_acerto(o0[12]), .led_erro(o0[13]), .pronto(o0[14]), .db_timeout(o0[15]),
        .db_estado(o0[19:16])
    );

    unidade_controle_quiz #(.TIMEOUT_ENCERRA(1'b1)) dut1 (
        .clock(clock), .reset(reset), .iniciar(iniciar), .dificuldade(dificuldade),
        .fez_jogada(fez_jogada), .jogada_igual_memoria(jogada_igual_memoria),
        .ultima_jogada(ultima_jogada), .deu_timeout(deu_timeout),
        .fim_timer_resultado(fim_timer_resultado),
        .dificuldade_travada(o1[0]), .zera_contador_jogada(o1[1]), .zera_contador_score(o1[2]),
        .zera_timer_resultado(o1[3]), .zera_timeout(o1[4]), .zeraR(o1[5]),
        .conta_jogada(o1[6]), .conta_score(o1[7]), .conta_timer_resultado(o1[8]),
        .conta_timeout(o1[9]), .registraR(o1[10]), .liga_led(o1[11]),
        .led_acerto(o1[12]), .led_erro(o1[13]), .pronto(o1[14]), .db_timeout(o1[15]),
        .db_estado(o1[19:16])
    );

    task automatic add(input logic [7:0] inp, input logic [3:0] st, input logic [15:0] mask);
        vec_t v;
        v.inp  = inp;
        v.st   = st;
        v.mask = mask;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] inp);
        {reset, iniciar, dificuldade, fez_jogada, jogada_igual_memoria,
         ultima_jogada, deu_timeout, fim_timer_resultado} = inp;
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got estado=%0d outs=%h, expected estado=%0d outs=%h",
                     name, act[19:16], act[15:0], exp[19:16], exp[15:0]);
        end
    endtask

    task automatic run_vec(input int i);
        drive(vecs[i].inp);
        @(posedge clock);
        #1;
        check($sformatf("vec%0d", i), o0, {vecs[i].st, vecs[i].mask});
        if (o0[7]) n_cs++;
        if (o0[6]) n_cj++;
    endtask

    task automatic step(input logic [7:0] inp);
        drive(inp);
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(8'b0000_0000);

        // Game 1: rounds correct, correct (fez+deu together), timeout, correct on last round
        add(8'b1000_0000, 4'd0,  16'h0000);
        add(8'b0100_0000, 4'd1,  ZALL);
        add(8'b0000_0000, 4'd2,  LED | CT);
        add(8'b0000_0000, 4'd2,  LED | CT);
        add(8'b0001_1000, 4'd3,  LED | REG);
        add(8'b0000_1000, 4'd4,  LED);
        add(8'b0000_1000, 4'd5,  CS | ZTR);
        add(8'b0010_0000, 4'd8,  CTR | LA);
        add(8'b0010_0000, 4'd8,  CTR | LA);
        add(8'b0010_0001, 4'd9,  CJ | ZT | ZR);
        add(8'b0010_0000, 4'd2,  LED | CT);
        add(8'b0011_1010, 4'd3,  LED | REG);
        add(8'b0010_1000, 4'd4,  LED);
        add(8'b0010_1000, 4'd5,  CS | ZTR);
        add(8'b0010_0000, 4'd8,  CTR | LA);
        add(8'b0010_0001, 4'd9,  CJ | ZT | ZR);
        add(8'b0010_0000, 4'd2,  LED | CT);
        add(8'b0010_0010, 4'd7,  ZTR);
        add(8'b0010_0000, 4'd8,  CTR | LE | DBT);
        add(8'b0010_0001, 4'd9,  CJ | ZT | ZR | DBT);
        add(8'b0010_0000, 4'd2,  LED | CT);
        add(8'b0011_1100, 4'd3,  LED | REG);
        add(8'b0010_1100, 4'd4,  LED);
        add(8'b0010_1100, 4'd5,  CS | ZTR);
        add(8'b0010_0100, 4'd8,  CTR | LA);
        add(8'b0010_0101, 4'd10, PR);
        add(8'b0010_0100, 4'd10, PR);
        // Game 2: restart from FIM with dificuldade=1, wrong answer, reset during EXIBE
        add(8'b0110_0000, 4'd1,  ZALL);
        add(8'b0110_0000, 4'd2,  LED | CT | DT);
        add(8'b0111_0000, 4'd3,  LED | REG | DT);
        add(8'b0110_0000, 4'd4,  LED | DT);
        add(8'b0110_0000, 4'd6,  ZTR | DT);
        add(8'b0110_0000, 4'd8,  CTR | LE | DT);
        add(8'b0110_0000, 4'd8,  CTR | LE | DT);
        add(8'b1110_0001, 4'd0,  16'h0000);
        add(8'b0000_0000, 4'd0,  16'h0000);

        #2;
        for (int i = 0; i < 27; i++) run_vec(i);

        tests++;
        if (n_cs != 3) begin
            fails++;
            $display("FAIL score_pulses: got %0d, expected 3", n_cs);
        end
        tests++;
        if (n_cj != 3) begin
            fails++;
            $display("FAIL jogada_pulses: got %0d, expected 3", n_cj);
        end

        for (int i = 27; i < vecs.size(); i++) run_vec(i);

        // Timeout with TIMEOUT_ENCERRA=1 ends the game; the =0 instance continues
        step(8'b1000_0000);
        check("te1_reset", o1, {4'd0, 16'h0000});
        step(8'b0100_0000);
        step(8'b0000_0000);
        check("te1_espera", o1, {4'd2, LED | CT});
        step(8'b0000_0010);
        check("te1_timeout", o1, {4'd7, ZTR});
        step(8'b0000_0000);
        check("te1_exibe", o1, {4'd8, CTR | LE | DBT});
        step(8'b0000_0001);
        check("te1_fim", o1, {4'd10, PR | DBT});
        check("te0_proxima", o0, {4'd9, CJ | ZT | ZR | DBT});
        step(8'b0000_0000);
        check("te1_fim_hold", o1, {4'd10, PR | DBT});
        check("te0_espera_clr", o0, {4'd2, LED | CT});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
